// File: rtl/sample_hex_streamer.sv
// sample_hex_streamer
//   Buffers ADC samples in a small FIFO and streams each one as an
//   uppercase ASCII hex text line (ND digits, CR, LF) over a registered,
//   back-pressured byte stream toward a UART transmitter.
//
//   Optional build macro: SAMPLE_HEX_STREAMER_SEQ_EN
//     When defined, every line is prefixed by a 4-digit hex sequence number
//     and a space; the 16-bit sequence counter advances per completed line.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data, in_valid  sample and its one-cycle strobe (no backpressure)
//   en                 streaming enable (sampled only between lines)
//   tdata, tvalid      ASCII byte stream out (held until handshake)
//   tready             downstream accepts the byte
//   overflow           sticky: a sample was dropped on a full FIFO
//   drop_count         saturating count of dropped samples
//   fifo_level         current FIFO occupancy
module sample_hex_streamer #(
   parameter int SAMPLE_BITLEN = 24,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SAMPLE_BITLEN-1:0]    in_data,
   input  logic                        in_valid,
   input  logic                        en,
   output logic [7:0]                  tdata,
   output logic                        tvalid,
   input  logic                        tready,
   output logic                        overflow,
   output logic [15:0]                 drop_count,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int ND = (SAMPLE_BITLEN + 3) / 4;  // hex digits per line
   localparam int LW = 4 * ND;                   // zero-extended line width
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int IW = 4;                        // holds up to ND-1 (<=7) and 4

`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
   typedef enum logic [2:0] {S_IDLE, S_SEQ, S_DIGIT, S_CR, S_LF} state_t;
   localparam state_t S_FIRST = S_SEQ;
`else
   typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;
   localparam state_t S_FIRST = S_DIGIT;
`endif

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // ---------------------------------------------------------------- FIFO
   logic [SAMPLE_BITLEN-1:0] mem [FIFO_DEPTH];
   logic [PW:0]              wptr, rptr;
   logic                     empty, full, push, pop;

   assign empty      = (wptr == rptr);
   assign full       = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push       = in_valid && (!full || pop);
   assign fifo_level = wptr - rptr;

   always_ff @(posedge clk) begin
      if (push) mem[wptr[PW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         overflow   <= 1'b0;
         drop_count <= 16'h0000;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (in_valid && !push) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'h0001;
         end
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t          state, state_n;
   logic [IW-1:0]   idx, idx_n;
   logic [LW-1:0]   line, line_n;     // MSB nibble is always the next digit
   logic            hs, start, line_done;
   logic [7:0]      tdata_n;
   logic            tvalid_n;

   assign hs = tvalid & tready;

`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
   logic [15:0] seq_cnt, seq_n;
   assign seq_n = line_done ? seq_cnt + 16'h0001 : seq_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seq_cnt <= 16'h0000;
      else        seq_cnt <= seq_n;
   end
`endif

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      line_n    = line;
      start     = 1'b0;
      line_done = 1'b0;
      case (state)
         S_IDLE:  start = en && !empty;
`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
         S_SEQ: if (hs) begin
            // idx 0..3 are the counter digits, idx 4 is the space
            if (idx == IW'(4)) begin
               state_n = S_DIGIT;
               idx_n   = '0;
            end else begin
               idx_n = idx + 1'b1;
            end
         end
`endif
         S_DIGIT: if (hs) begin
            line_n = line << 4;
            if (idx == IW'(ND - 1)) state_n = S_CR;
            else                    idx_n   = idx + 1'b1;
         end
         S_CR:    if (hs) state_n = S_LF;
         S_LF:    if (hs) begin
            line_done = 1'b1;
            // chain straight into the next line to avoid a bubble
            if (en && !empty) start   = 1'b1;
            else              state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (start) begin
         line_n  = LW'(mem[rptr[PW-1:0]]);
         idx_n   = '0;
         state_n = S_FIRST;
      end
   end

   assign pop = start;

   // Output byte is computed from the next state so tdata/tvalid can be
   // registered; without a handshake the inputs here are unchanged, which
   // keeps the byte stable while stalled.
   always_comb begin
      tdata_n  = 8'h00;
      tvalid_n = (state_n != S_IDLE);
      case (state_n)
`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
         S_SEQ: begin
            case (idx_n[2:0])
               3'd0:    tdata_n = hex_ascii(seq_n[15:12]);
               3'd1:    tdata_n = hex_ascii(seq_n[11:8]);
               3'd2:    tdata_n = hex_ascii(seq_n[7:4]);
               3'd3:    tdata_n = hex_ascii(seq_n[3:0]);
               default: tdata_n = 8'h20;
            endcase
         end
`endif
         S_DIGIT: tdata_n = hex_ascii(line_n[LW-1 -: 4]);
         S_CR:    tdata_n = 8'h0D;
         S_LF:    tdata_n = 8'h0A;
         default: tdata_n = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         line   <= '0;
         tdata  <= 8'h00;
         tvalid <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         line   <= line_n;
         tdata  <= tdata_n;
         tvalid <= tvalid_n;
      end
   end

endmodule

// File: tb/tb_sample_hex_streamer.sv
module tb_sample_hex_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, tready = 1'b0;
   // 24-bit instance (default parameters)
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  tdata;
   logic        tvalid, overflow;
   logic [15:0] drop_count;
   logic [4:0]  fifo_level;
   // 20-bit instance
   logic [19:0] in_data20 = '0;
   logic        in_valid20 = 1'b0;
   logic [7:0]  tdata20;
   logic        tvalid20, overflow20;
   logic [15:0] drop_count20;
   logic [4:0]  fifo_level20;

   always #5 clk = ~clk;

   sample_hex_streamer dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .en(en),
      .tdata(tdata), .tvalid(tvalid), .tready(tready), .overflow(overflow),
      .drop_count(drop_count), .fifo_level(fifo_level));

   sample_hex_streamer #(.SAMPLE_BITLEN(20), .FIFO_DEPTH(16)) dut20 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data20), .in_valid(in_valid20), .en(en),
      .tdata(tdata20), .tvalid(tvalid20), .tready(tready), .overflow(overflow20),
      .drop_count(drop_count20), .fifo_level(fifo_level20));

`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
   localparam int PFX = 5;
`else
   localparam int PFX = 0;
`endif
   localparam int LINE24 = PFX + 6 + 2;

   int compared = 0, failed = 0;
   int seq24 = 0, seq20 = 0;
   logic [7:0] expq[$];
   logic [7:0] rx[$];
   bit   mon_on = 1'b0;

   typedef struct {
      logic [31:0] s;
      logic [63:0] txt;   // expected hex digits, right-justified ASCII
      bit          w20;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hexch(input int n);
      string h = "0123456789ABCDEF";
      return h[n];
   endfunction

   task automatic push_prefix(input int seq);
`ifdef SAMPLE_HEX_STREAMER_SEQ_EN
      for (int k = 3; k >= 0; k--) expq.push_back(hexch((seq >> (4 * k)) & 15));
      expq.push_back(8'h20);
`else
      if (seq < 0) expq.push_back(8'h00);  // never true; keeps the arg used
`endif
   endtask

   // Reference line for a sample: digits from plain arithmetic on the value.
   task automatic push_exp(input logic [31:0] s, input int nd, input int seq);
      push_prefix(seq & 16'hFFFF);
      for (int k = nd - 1; k >= 0; k--) expq.push_back(hexch(int'((s >> (4 * k)) & 32'hF)));
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
   endtask

   task automatic cmp_streams(input string name);
      int bad = 0;
      chk({name, "_len"}, rx.size(), expq.size());
      for (int i = 0; i < rx.size() && i < expq.size() && bad < 8; i++) begin
         compared++;
         if (rx[i] !== expq[i]) begin
            failed++; bad++;
            $display("FAIL %s byte %0d: got %02h expected %02h", name, i, rx[i], expq[i]);
         end
      end
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c = 0;
      while (rx.size() < n && c < budget) begin @(posedge clk); c++; end
      #1;
      if (rx.size() < n) chk("wait_rx_timeout", rx.size(), n);
   endtask

   // Single sample into an idle block: latency and back-to-back bytes.
   task automatic check_line(input logic [31:0] s, input logic [63:0] txt, input bit w20);
      int nd = w20 ? 5 : 6;
      expq.delete();
      push_prefix(w20 ? seq20 : seq24);
      for (int k = 0; k < nd; k++) expq.push_back(txt[8 * (nd - 1 - k) +: 8]);
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
      @(posedge clk); #1;
      if (w20) begin in_valid20 = 1'b1; in_data20 = s[19:0]; end
      else     begin in_valid   = 1'b1; in_data   = s[23:0]; end
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid20 = 1'b0;
      chk("level_after_push", w20 ? fifo_level20 : fifo_level, 1);
      chk("tvalid_before_first", w20 ? tvalid20 : tvalid, 0);
      @(posedge clk); #1;
      for (int i = 0; i < expq.size(); i++) begin
         chk($sformatf("line_%0h_byte%0d", s, i),
             w20 ? {tvalid20, tdata20} : {tvalid, tdata}, {1'b1, expq[i]});
         @(posedge clk); #1;
      end
      chk("tvalid_after_line", w20 ? tvalid20 : tvalid, 0);
      if (w20) seq20++; else seq24++;
   endtask

   // Byte capture plus hold-while-stalled check on the 24-bit instance.
   logic       stalled = 1'b0;
   logic [7:0] held = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mon_on && tvalid && tready) rx.push_back(tdata);
         if (stalled) begin
            compared++;
            if (!tvalid || tdata !== held) begin
               failed++;
               $display("FAIL stall_hold: got v=%0b d=%02h expected v=1 d=%02h", tvalid, tdata, held);
            end
         end
         stalled = tvalid && !tready;
         held    = tdata;
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [23:0] ov[16];
   logic [23:0] x, s1, s2;
   int sent, lines;

   initial begin
      vecs[0] = '{32'h12AB3F, "12AB3F", 1'b0};
      vecs[1] = '{32'hFFFFFF, "FFFFFF", 1'b0};
      vecs[2] = '{32'h000000, "000000", 1'b0};
      vecs[3] = '{32'h09A5F0, "09A5F0", 1'b0};
      vecs[4] = '{32'hFFFFF,  "FFFFF",  1'b1};
      vecs[5] = '{32'h00000,  "00000",  1'b1};
      vecs[6] = '{32'h5C3A1,  "5C3A1",  1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_level", fifo_level, 0);
      rst_n = 1'b1;
      en = 1'b1; tready = 1'b1;

      // table-driven single lines
      for (int i = 0; i < 7; i++) check_line(vecs[i].s, vecs[i].txt, vecs[i].w20);

      // reset mid-line: three bytes out, two samples waiting
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = 24'hABC000 + 24'(i);
      end
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_level", fifo_level, 2);
      chk("pre_reset_tvalid", tvalid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tvalid", tvalid, 0);
      chk("async_rst_level", fifo_level, 0);
      chk("async_rst_overflow", overflow, 0);
      chk("async_rst_drop", drop_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; seq24 = 0; seq20 = 0;
      check_line(32'h7E0D15, "7E0D15", 1'b0);

      // overflow: fill with en low and the sink stalled
      en = 1'b0; tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = 24'($urandom);
         if (i < 16) ov[i] = in_data;
      end
      @(posedge clk); #1; in_valid = 1'b0;
      chk("full_level", fifo_level, 16);
      chk("full_overflow", overflow, 1);
      chk("full_drop", drop_count, 4);
      chk("full_tvalid", tvalid, 0);
      // push coinciding with the first pop of a full FIFO is accepted
      x = 24'($urandom);
      en = 1'b1; in_valid = 1'b1; in_data = x;
      @(posedge clk); #1; in_valid = 1'b0;
      chk("pushpop_level", fifo_level, 16);
      chk("pushpop_drop", drop_count, 4);
      chk("pushpop_tvalid", tvalid, 1);
      expq.delete(); rx.delete();
      for (int i = 0; i < 16; i++) begin push_exp(ov[i], 6, seq24); seq24++; end
      push_exp(x, 6, seq24); seq24++;
      mon_on = 1'b1; tready = 1'b1;
      wait_rx(expq.size(), 2000);
      repeat (4) @(posedge clk); #1;
      cmp_streams("overflow_drain");
      chk("drained_level", fifo_level, 0);

      // random samples, random stalls and enable
      expq.delete(); rx.delete();
      sent = 0;
      while (sent < 100) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         tready = ($urandom_range(0, 99) < 60);
         en     = ($urandom_range(0, 99) < 90);
         lines  = rx.size() / LINE24;
         if ((sent - lines) < 10 && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1; in_data = 24'($urandom);
            push_exp(in_data, 6, seq24); seq24++;
            sent++;
         end
      end
      @(posedge clk); #1; in_valid = 1'b0; en = 1'b1;
      for (int c = 0; c < 20000 && rx.size() < expq.size(); c++) begin
         @(posedge clk); #1; tready = ($urandom_range(0, 99) < 60);
      end
      tready = 1'b1;
      wait_rx(expq.size(), 10);
      cmp_streams("random");
      chk("random_no_drop", drop_count, 4);

      // en dropped mid-line: the line finishes, the next one waits
      expq.delete(); rx.delete();
      s1 = 24'h000001; s2 = 24'h000002;
      @(posedge clk); #1; in_valid = 1'b1; in_data = s1;
      @(posedge clk); #1; in_data = s2;
      @(posedge clk); #1; in_valid = 1'b0;
      chk("en_tvalid_up", tvalid, 1);
      en = 1'b0;
      push_exp(s1, 6, seq24); seq24++;
      repeat (20) @(posedge clk); #1;
      cmp_streams("en_low_line");
      chk("en_low_tvalid", tvalid, 0);
      chk("en_low_level", fifo_level, 1);
      en = 1'b1;
      push_exp(s2, 6, seq24); seq24++;
      repeat (20) @(posedge clk); #1;
      cmp_streams("en_resume");
      mon_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
